// File: rtl/itch_spec_frame_parser.sv
`default_nettype none
// ============================================================================
//  Module      : itch_spec_frame_parser
//  Description : Speculative ITCH framer. Dispatches the message type one
//                cycle after the type byte, parses a big-endian length of
//                LEN_BYTES bytes, range-checks it and streams the payload
//                with valid/ready. Bad lengths and idle timeouts retract the
//                speculative dispatch through spec_cancel.
//  Revision    : 1.0 - initial release
// ============================================================================
module itch_spec_frame_parser #(
    parameter int LEN_BYTES = 2,
    parameter int MAX_LEN   = 64,
    parameter int TIMEOUT   = 256,
    parameter int ERR_W     = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [7:0]             rx_data,
    input  logic                   rx_valid,
    output logic                   rx_ready,
    output logic [7:0]             msg_type,
    output logic                   spec_valid,
    output logic [8*LEN_BYTES-1:0] msg_len,
    output logic                   header_valid,
    output logic                   spec_cancel,
    output logic [7:0]             pay_data,
    output logic                   pay_valid,
    input  logic                   pay_ready,
    output logic                   pay_last,
    output logic                   msg_done,
    output logic [ERR_W-1:0]       err_cnt
);

    localparam int c_LEN_W    = 8 * LEN_BYTES;
    localparam int c_IDX_W    = (LEN_BYTES > 1) ? $clog2(LEN_BYTES) : 1;
    localparam int c_REM_RAW  = $clog2(MAX_LEN + 1);
    localparam int c_REM_W    = (c_REM_RAW > c_LEN_W) ? c_LEN_W : c_REM_RAW;
    localparam int c_IDLE_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LEN     = 2'd1,
        S_PAYLOAD = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_IDX_W-1:0]   r_idx,          w_idx_next;
    logic [c_REM_W-1:0]   r_rem,          w_rem_next;
    logic [c_IDLE_W-1:0]  r_idle_cnt,     w_idle_next;
    logic [7:0]           r_msg_type,     w_msg_type_next;
    logic [c_LEN_W-1:0]   r_msg_len,      w_msg_len_next;
    logic [ERR_W-1:0]     r_err_cnt,      w_err_next;
    logic                 r_spec_valid,   w_spec_valid_next;
    logic                 r_header_valid, w_header_valid_next;
    logic                 r_spec_cancel,  w_spec_cancel_next;
    logic                 r_msg_done,     w_msg_done_next;

    logic                 w_accept;
    logic                 w_last_len;
    logic                 w_len_ok;
    logic                 w_timeout;
    logic [c_LEN_W-1:0]   w_len_next;

    assign w_accept   = rx_valid && rx_ready;
    assign w_last_len = (r_idx == c_IDX_W'(LEN_BYTES - 1));
    assign w_len_ok   = (w_len_next != '0) && (32'(w_len_next) <= 32'(MAX_LEN));

    // Length accumulator: the first length byte discards the previous message's length
    generate
        if (LEN_BYTES == 1) begin : g_len_single
            assign w_len_next = rx_data;
        end else begin : g_len_multi
            assign w_len_next = (r_idx == '0) ? {{(c_LEN_W-8){1'b0}}, rx_data}
                                              : {r_msg_len[c_LEN_W-9:0], rx_data};
        end
    endgenerate

    // Source-idle timeout only ever fires on a cycle without a valid byte
    generate
        if (TIMEOUT > 0) begin : g_timeout
            assign w_timeout = (r_state != S_IDLE) && !rx_valid &&
                               (r_idle_cnt == c_IDLE_W'(TIMEOUT - 1));
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

    // Next-state and next-value logic for the framer
    always_comb begin
        w_state_next        = r_state;
        w_idx_next          = r_idx;
        w_rem_next          = r_rem;
        w_msg_type_next     = r_msg_type;
        w_msg_len_next      = r_msg_len;
        w_err_next          = r_err_cnt;
        w_spec_valid_next   = 1'b0;
        w_header_valid_next = 1'b0;
        w_spec_cancel_next  = 1'b0;
        w_msg_done_next     = 1'b0;
        w_idle_next         = (r_state == S_IDLE || rx_valid) ? '0
                                                              : r_idle_cnt + c_IDLE_W'(1);
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_msg_type_next   = rx_data;
                    w_spec_valid_next = 1'b1;
                    w_idx_next        = '0;
                    w_state_next      = S_LEN;
                end
            end
            S_LEN: begin
                if (w_accept) begin
                    w_msg_len_next = w_len_next;
                    w_idx_next     = r_idx + c_IDX_W'(1);
                    if (w_last_len) begin
                        if (w_len_ok) begin
                            w_header_valid_next = 1'b1;
                            w_rem_next          = w_len_next[c_REM_W-1:0];
                            w_state_next        = S_PAYLOAD;
                        end else begin
                            w_spec_cancel_next = 1'b1;
                            w_state_next       = S_IDLE;
                        end
                    end
                end else if (w_timeout) begin
                    w_spec_cancel_next = 1'b1;
                    w_state_next       = S_IDLE;
                end
            end
            S_PAYLOAD: begin
                if (w_accept) begin
                    w_rem_next = r_rem - c_REM_W'(1);
                    if (r_rem == c_REM_W'(1)) begin
                        w_msg_done_next = 1'b1;
                        w_state_next    = S_IDLE;
                    end
                end else if (w_timeout) begin
                    w_spec_cancel_next = 1'b1;
                    w_rem_next         = '0;
                    w_state_next       = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
        if (w_spec_cancel_next) begin
            w_idle_next = '0;
            if (r_err_cnt != '1) begin
                w_err_next = r_err_cnt + ERR_W'(1);
            end
        end
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_idx          <= '0;
            r_rem          <= '0;
            r_idle_cnt     <= '0;
            r_msg_type     <= '0;
            r_msg_len      <= '0;
            r_err_cnt      <= '0;
            r_spec_valid   <= 1'b0;
            r_header_valid <= 1'b0;
            r_spec_cancel  <= 1'b0;
            r_msg_done     <= 1'b0;
        end else begin
            r_state        <= w_state_next;
            r_idx          <= w_idx_next;
            r_rem          <= w_rem_next;
            r_idle_cnt     <= w_idle_next;
            r_msg_type     <= w_msg_type_next;
            r_msg_len      <= w_msg_len_next;
            r_err_cnt      <= w_err_next;
            r_spec_valid   <= w_spec_valid_next;
            r_header_valid <= w_header_valid_next;
            r_spec_cancel  <= w_spec_cancel_next;
            r_msg_done     <= w_msg_done_next;
        end
    end

    // Payload is a zero-latency pass-through; backpressure only applies in PAYLOAD
    assign rx_ready     = (r_state == S_PAYLOAD) ? pay_ready : 1'b1;
    assign pay_valid    = rx_valid && (r_state == S_PAYLOAD);
    assign pay_data     = rx_data;
    assign pay_last     = pay_valid && (r_rem == c_REM_W'(1));

    assign msg_type     = r_msg_type;
    assign msg_len      = r_msg_len;
    assign spec_valid   = r_spec_valid;
    assign header_valid = r_header_valid;
    assign spec_cancel  = r_spec_cancel;
    assign msg_done     = r_msg_done;
    assign err_cnt      = r_err_cnt;

endmodule
`default_nettype wire
